// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with PC, single-outstanding imem port and 2-entry decode buffer
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [5:0]        opcode,
  output logic [5:0]        funct
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_pc_nx;
  logic              discard;
  logic              discard_nx;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_aligned;

  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [31:0]       buf_data [2];
  logic [ADDR_W-1:0] buf_pc   [2];

  // Low target bits are architecturally meaningless; only the aligned part is kept.
  logic              unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_aligned     = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign imem_addr   = pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = buf_data[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];

  // A redirect flushes the buffer, so a same-edge pop must not move the read side.
  assign pop = instr_valid && instr_ready && !redirect_valid;

  // Fetch FSM state, PC, outstanding request address and discard flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      req_pc  <= req_pc_nx;
      discard <= discard_nx;
    end
  end

  // Next-state logic: issue when the buffer has room, accept responses, then apply redirect overrides.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    req_pc_nx      = req_pc;
    discard_nx     = discard;
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    push           = 1'b0;

    case (state)
      S_IDLE: begin
        state_nx = S_REQ;
      end
      S_REQ: begin
        imem_req_valid = (count < 2'd2);
        req_fire       = imem_req_valid && imem_req_ready;
        if (req_fire) begin
          req_pc_nx = pc;
          pc_nx     = pc + ADDR_W'(4);
          state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          push       = !discard;
          discard_nx = 1'b0;
          state_nx   = S_REQ;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // The redirect target wins over any sequential PC update; an accepted or
    // still-pending request becomes stale and its response is thrown away.
    if (redirect_valid) begin
      pc_nx = redirect_aligned;
      push  = 1'b0;
      case (state)
        S_REQ: begin
          if (req_fire) begin
            discard_nx = 1'b1;
          end
        end
        S_WAIT: begin
          if (!imem_rsp_valid) begin
            discard_nx = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Two-entry instruction buffer; a response only arrives when there is room for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else if (redirect_valid) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= imem_rsp_data;
        buf_pc[wr_ptr]   <= req_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a queue-based fetch model
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  logic        w_rst_n;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [7:0]  w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [7:0]  w_redirect_pc;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic [31:0] w_instr;
  logic [7:0]  w_instr_pc;
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct(funct)
  );

  instr_fetch #(.ADDR_W(8), .RESET_PC(8'hF8)) u_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
    .opcode(w_opcode), .funct(w_funct)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: fetch PC, buffered addresses, one outstanding memory request.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_started;
  bit          m_pend;
  bit          m_kill;
  logic [31:0] m_paddr;
  int          m_delay;
  int          mem_lat  = 0;
  bit          lat_rand = 1'b0;
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0000_0020;
    if (a == 32'h14) return 32'h8C00_0000;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_init();
    m_pc      = 32'h0;
    m_q.delete();
    m_started = 1'b0;
    m_pend    = 1'b0;
    m_kill    = 1'b0;
    m_paddr   = 32'h0;
    m_delay   = 0;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model across the edge.
  task automatic cycle(input bit rq_rdy, input bit in_rdy, input bit redir, input logic [31:0] rpc);
    bit          exp_rv;
    bit          rsp_now;
    bit          hs;
    bit          pop;
    logic [31:0] exp_d;
    exp_rv = m_started && !m_pend && (m_q.size() < 2);
    total++;
    if (imem_req_valid !== exp_rv) begin
      bad++;
      $display("FAIL req_valid: got %b want %b at %0t", imem_req_valid, exp_rv, $time);
    end
    if (exp_rv) begin
      total++;
      if (imem_addr !== m_pc) begin
        bad++;
        $display("FAIL imem_addr: got %h want %h at %0t", imem_addr, m_pc, $time);
      end
    end
    total++;
    if (instr_valid !== (m_q.size() != 0)) begin
      bad++;
      $display("FAIL instr_valid: got %b want %b at %0t", instr_valid, (m_q.size() != 0), $time);
    end
    if (m_q.size() != 0) begin
      exp_d = mem_word(m_q[0]);
      total++;
      if (instr_pc !== m_q[0]) begin
        bad++;
        $display("FAIL instr_pc: got %h want %h at %0t", instr_pc, m_q[0], $time);
      end
      total++;
      if (instr !== exp_d) begin
        bad++;
        $display("FAIL instr: got %h want %h at %0t", instr, exp_d, $time);
      end
      total++;
      if (opcode !== exp_d[31:26] || funct !== exp_d[5:0]) begin
        bad++;
        $display("FAIL fields: got %h/%h want %h/%h at %0t", opcode, funct, exp_d[31:26], exp_d[5:0], $time);
      end
    end
    rsp_now = m_pend && (m_delay == 0);
    hs      = exp_rv && rq_rdy;
    pop     = (m_q.size() != 0) && in_rdy;
    if (imem_req_valid && rq_rdy) acc_log.push_back(imem_addr);
    if (instr_valid && in_rdy && !redir) del_log.push_back(instr_pc);
    imem_req_ready = rq_rdy;
    instr_ready    = in_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(m_paddr) : $urandom;
    @(posedge clk);
    if (m_pend && !rsp_now) m_delay--;
    if (redir) begin
      m_q.delete();
      if (m_pend && !rsp_now) m_kill = 1'b1;
    end else begin
      if (pop) m_q.delete(0);
      if (rsp_now && !m_kill) m_q.push_back(m_paddr);
    end
    if (rsp_now) m_pend = 1'b0;
    if (hs) begin
      m_pend  = 1'b1;
      m_kill  = redir;
      m_paddr = m_pc;
      m_delay = lat_rand ? int'($urandom_range(0, 2)) : mem_lat;
      m_pc    = m_pc + 32'd4;
    end
    if (redir) m_pc = {rpc[31:2], 2'b00};
    m_started = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
  endtask

  // Asynchronous reset from mid-operation; called at a falling edge.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: got rv=%b iv=%b instr=%h pc=%h want all zero", imem_req_valid, instr_valid, instr, instr_pc);
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init();
    acc_log.delete();
    del_log.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_rsp_valid = 1'($urandom);
      imem_req_ready = 1'($urandom);
      instr_ready    = 1'($urandom);
      imem_rsp_data  = $urandom;
      #1;
      total++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
          opcode !== 6'h0 || funct !== 6'h0 || imem_addr !== 32'h0) begin
        bad++;
        $display("FAIL reset_hold: got rv=%b iv=%b instr=%h pc=%h addr=%h want zeros", imem_req_valid, instr_valid, instr, instr_pc, imem_addr);
      end
    end
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_idle: got %b want 0", imem_req_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req: got rv=%b addr=%h iv=%b want 1/0/0", imem_req_valid, imem_addr, instr_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stray_rsp: got rv=%b addr=%h iv=%b want 1/0/0", imem_req_valid, imem_addr, instr_valid);
    end
    imem_rsp_valid = 1'b0;
    model_init();
    m_started = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    mem_lat  = 0;
    lat_rand = 1'b0;
    repeat (24) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++;
    if (acc_log.size() != 12) begin
      bad++;
      $display("FAIL seq_throughput: got %0d requests want 12", acc_log.size());
    end
    total++;
    if (acc_log.size() < 4 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8 || acc_log[3] !== 32'hC) begin
      bad++;
      $display("FAIL seq_order: got %0d entries starting %h want 0,4,8,c", acc_log.size(), (acc_log.size() != 0) ? acc_log[0] : 32'hX);
    end
  endtask

  task automatic test_fields();
    int n;
    do_reset();
    n = 0;
    while (n < 40 && !(m_q.size() != 0 && m_q[0] == 32'h10)) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    total++;
    if (opcode !== 6'h00 || funct !== 6'h20 || instr_pc !== 32'h10) begin
      bad++;
      $display("FAIL fields_r: got op=%h fn=%h pc=%h want 00/20/10", opcode, funct, instr_pc);
    end
    n = 0;
    while (n < 40 && !(m_q.size() != 0 && m_q[0] == 32'h14)) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    total++;
    if (opcode !== 6'h23 || funct !== 6'h00 || instr_pc !== 32'h14) begin
      bad++;
      $display("FAIL fields_lw: got op=%h fn=%h pc=%h want 23/00/14", opcode, funct, instr_pc);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    do_reset();
    mem_lat = 0;
    repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || acc_log.size() != 2) begin
      bad++;
      $display("FAIL bp_full: got rv=%b iv=%b reqs=%0d want 0/1/2", imem_req_valid, instr_valid, acc_log.size());
    end
    n0 = acc_log.size();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if (acc_log.size() - n0 != 1) begin
      bad++;
      $display("FAIL bp_release: got %0d new requests want 1", acc_log.size() - n0);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset();
    mem_lat = 1;
    n = 0;
    while (n < 40 && !(m_pend && m_paddr == 32'h8 && m_delay > 0)) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL rw_setup: got no wait for 0x8 within %0d cycles want one", n);
    end
    acc_log.delete();
    del_log.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h103);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h100) begin
      bad++;
      $display("FAIL rw_next_req: got %h want 100", (acc_log.size() != 0) ? acc_log[0] : 32'hX);
    end
    total++;
    if (del_log.size() == 0 || del_log[0] !== 32'h100) begin
      bad++;
      $display("FAIL rw_first_instr: got %h want 100", (del_log.size() != 0) ? del_log[0] : 32'hX);
    end
    mem_lat = 0;
  endtask

  task automatic test_redirect_hs();
    int n;
    do_reset();
    mem_lat = 0;
    n = 0;
    while (n < 40 && !(m_started && !m_pend && m_q.size() < 2 && m_pc == 32'h4)) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    acc_log.delete();
    del_log.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h4 || acc_log[1] !== 32'h40 || acc_log[2] !== 32'h44) begin
      bad++;
      $display("FAIL rh_order: got %0d reqs second %h want 4,40,44", acc_log.size(), (acc_log.size() > 1) ? acc_log[1] : 32'hX);
    end
    total++;
    if (del_log.size() == 0 || del_log[0] !== 32'h40) begin
      bad++;
      $display("FAIL rh_first_instr: got %h want 40", (del_log.size() != 0) ? del_log[0] : 32'hX);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0), $urandom & 32'h0000_0FFF);
    end
    lat_rand = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] wpc;
    logic [7:0] wpaddr;
    logic [7:0] wq[$];
    logic [7:0] wacc[$];
    bit         wpend;
    bit         wexp;
    bit         wrsp;
    bit         wpop;
    bit         wrdy;
    wpc    = 8'hF8;
    wpaddr = 8'h0;
    wpend  = 1'b0;
    @(negedge clk);
    w_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      wexp = !wpend && (wq.size() < 2);
      total++;
      if (w_req_valid !== wexp || (wexp && w_addr !== wpc)) begin
        bad++;
        $display("FAIL wrap_req: got rv=%b addr=%h want %b/%h", w_req_valid, w_addr, wexp, wpc);
      end
      total++;
      if (w_instr_valid !== (wq.size() != 0) ||
          (wq.size() != 0 && (w_instr_pc !== wq[0] || w_instr !== {wq[0], 16'h1234, wq[0]}))) begin
        bad++;
        $display("FAIL wrap_head: got iv=%b pc=%h instr=%h want %b/%h", w_instr_valid, w_instr_pc, w_instr,
                 (wq.size() != 0), (wq.size() != 0) ? wq[0] : 8'hX);
      end
      wrsp = wpend;
      wrdy = ($urandom_range(0, 2) != 0);
      wpop = (wq.size() != 0) && wrdy;
      if (w_req_valid) wacc.push_back(w_addr);
      w_req_ready   = 1'b1;
      w_instr_ready = wrdy;
      w_rsp_valid   = wrsp;
      w_rsp_data    = {wpaddr, 16'h1234, wpaddr};
      @(posedge clk);
      if (wpop) wq.delete(0);
      if (wrsp) begin
        wq.push_back(wpaddr);
        wpend = 1'b0;
      end
      if (wexp) begin
        wpend  = 1'b1;
        wpaddr = wpc;
        wpc    = wpc + 8'd4;
      end
      @(negedge clk);
      w_rsp_valid = 1'b0;
    end
    total++;
    if (wacc.size() < 3 || wacc[0] !== 8'hF8 || wacc[1] !== 8'hFC || wacc[2] !== 8'h00) begin
      bad++;
      $display("FAIL wrap_order: got %0d reqs third %h want f8,fc,00", wacc.size(), (wacc.size() > 2) ? wacc[2] : 8'hX);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    imem_req_ready   = 1'b0;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = 32'h0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    instr_ready      = 1'b0;
    w_rst_n          = 1'b0;
    w_req_ready      = 1'b0;
    w_rsp_valid      = 1'b0;
    w_rsp_data       = 32'h0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 8'h0;
    w_instr_ready    = 1'b0;
    model_init();
    test_reset();
    test_sequential();
    test_fields();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hs();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the producer side of the control decoder's opcode/funct interface. It holds the PC and issues one word request at a time to instruction memory. Responses go into a 2-entry instruction buffer, which is presented to decode with a valid/ready handshake. Branch and jump redirects flush the buffer, discard any in-flight response and restart fetch at the new PC.

## Interface
Parameters:
- ADDR_W, 32, PC and memory address width
- RESET_PC, 0, first fetch address after reset (word aligned)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  ADDR_W  request byte address, bits [1:0] always 0
- imem_rsp_valid  in  1  one-cycle response strobe
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  single-cycle branch/jump redirect pulse
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode consumes head
- instr  out  32  head instruction word
- instr_pc  out  ADDR_W  address of head instruction
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]; decode uses funct[4:0]

## Operation
- Fetch states:
  - S_IDLE: reset state; unconditionally moves to S_REQ on the next edge.
  - S_REQ: imem_req_valid = (count < 2); imem_addr = pc. On req_valid && req_ready, pc <= pc + 4 (mod 2^ADDR_W) and the FSM moves to S_WAIT.
  - S_WAIT: waits for imem_rsp_valid. On response, the word and its address are pushed into the buffer unless dropped (see redirect rules). The FSM then returns to S_REQ.
- One outstanding request maximum. Issue only when count < 2, so a response always has room.
- The address of each outstanding request is held in req_pc and stored alongside the instruction.
- Buffer: 2-entry FIFO, count 0..2.
  - Push on an accepted response; pop on instr_valid && instr_ready.
  - Simultaneous push and pop leaves count unchanged, with correct order.
- instr_valid = (count != 0). instr, instr_pc, opcode and funct come directly from the head entry.
- Redirect (redirect_valid high at an edge) overrides everything else that edge:
  - count <= 0, pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Any pop in the same cycle is ignored; the buffer is flushed.
  - In S_WAIT without a same-cycle response: set discard, stay in S_WAIT. The next response is dropped, discard clears, and the FSM goes to S_REQ.
  - In S_WAIT with a same-cycle response: the response is dropped and the FSM goes to S_REQ.
  - In S_REQ with a same-cycle request handshake: the request is already accepted. Set discard, go to S_WAIT; its response is dropped. pc becomes redirect_pc, not redirect_pc + 4.
  - In S_REQ without a handshake: pc is updated and the FSM stays in S_REQ.
  - In S_IDLE: only pc is updated.
- imem_req_valid, once asserted, stays asserted with a stable imem_addr until accepted, unless a redirect occurs.
- A response arriving in S_REQ/S_IDLE (protocol violation) is ignored.

## Timing
- Reset values:
  - state S_IDLE, pc = RESET_PC, count 0, discard 0.
  - imem_req_valid 0, instr_valid 0, instr 0, instr_pc 0, opcode 0, funct 0.
- First imem_req_valid goes high in the cycle after the first rising edge following rst_n deassertion.
- Response-to-decode latency: a response sampled at edge N gives instr_valid high after edge N. A pop at the same edge N+1 is allowed.
- With 1-cycle memory and no backpressure, throughput is 1 instruction per 2 cycles (REQ, WAIT).
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - Any in-flight memory response after reset release is ignored, because the FSM is not in S_WAIT.
- PC wraps from 2^ADDR_W-4 to 0 with no flag.

## Test plan
- Reset: hold rst_n low, drive rsp_valid and ready randomly. All outputs stay at their reset values. After release, the first request has imem_addr = 0x0 one cycle after the first edge.
- Sequential fetch: memory with 1-cycle latency returns data = addr ^ 0xA5A50000, instr_ready = 1. Requests go to 0x0, 0x4, 0x8, 0xC. instr_pc and instr match in order. Opcode and funct fields are correct for 0x00000020 (opcode 0x00, funct 0x20) and 0x8C000000 (opcode 0x23).
- Backpressure: instr_ready = 0. Exactly 2 instructions are buffered, then imem_req_valid stays 0. Releasing instr_ready for one cycle allows exactly one new request.
- Redirect in S_WAIT: redirect_pc = 0x103 during an outstanding request for 0x8. The 0x8 response is dropped, the next request is to 0x100, and instr_valid stays 0 until that response arrives.
- Redirect coincident with request handshake for 0x4 (redirect_pc = 0x40): the 0x4 response is dropped, and the next request is 0x40, then 0x44.
- Wrap and simultaneous push/pop: ADDR_W = 8, RESET_PC = 0xF8, continuous ready. Fetch order is 0xF8, 0xFC, 0x00. count never exceeds 2 during overlapping push/pop.
